// File: rtl/com_stream_tx_pkg.sv
// Shared types for the COM stream transmitter: FSM states and the
// data-memory word shape seen as an array of byte lanes.
package com_stream_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  typedef logic [LANES-1:0][LANE_W-1:0] lane_vec_t;

endpackage

// File: rtl/com_stream_tx_if.sv
// Data-memory read port plus outgoing byte handshake of the COM transmitter.
interface com_stream_tx_if #(
  parameter int unsigned I = 32,
  parameter int unsigned N = 8,
  parameter int unsigned R = 6
);
  logic [I-1:0]   mem_addr;
  logic [R*N-1:0] mem_rd;
  logic [N-1:0]   byte_out;
  logic           byte_valid;
  logic           byte_ready;

  modport master (
    output mem_addr, byte_out, byte_valid,
    input  mem_rd, byte_ready
  );

  modport slave (
    input  mem_addr, byte_out, byte_valid,
    output mem_rd, byte_ready
  );
endinterface

// File: rtl/com_stream_tx_lane_serializer.sv
// Holds one fetched data-memory word and presents its lanes one at a time,
// lane 0 first, over a valid/ready handshake.
module lane_serializer #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [R-1:0][N-1:0] lanes_in,
  output logic [N-1:0]        byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                last_lane
);

  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0][N-1:0] lanes_q;
  logic [IW-1:0]       lane_idx;
  logic                active;
  logic                hs;
  logic                at_last;

  assign hs        = active & byte_ready;
  assign at_last   = (lane_idx == IW'(R - 1));
  assign last_lane = hs & at_last;

  // Output is forced to zero while no word is held so idle byte_out reads 0.
  assign byte_valid = active;
  assign byte_out   = active ? lanes_q[lane_idx] : '0;

  // Capture a word on load, then step through lanes on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q  <= '0;
      lane_idx <= '0;
      active   <= 1'b0;
    end else if (load) begin
      lanes_q  <= lanes_in;
      lane_idx <= '0;
      active   <= 1'b1;
    end else if (hs) begin
      if (at_last) begin
        active <= 1'b0;
      end else begin
        lane_idx <= lane_idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/com_stream_tx.sv
// COM stream transmitter: on a COM request reads word_count data-memory
// words starting at base_addr and streams each word out as R bytes.
module com_stream_tx
  import com_stream_pkg::*;
#(
  parameter int unsigned I  = 32,
  parameter int unsigned N  = 8,
  parameter int unsigned R  = 6,
  parameter int unsigned CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              com,
  input  logic [I-1:0]      base_addr,
  input  logic [CW-1:0]     word_count,
  com_stream_tx_if.master   bus,
  output logic              busy,
  output logic              done
);

  state_t         state_q;
  state_t         state_d;
  logic [I-1:0]   addr_q;
  logic [CW-1:0]  words_left;
  logic           load;
  logic           last_lane;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load strobes the serializer during the single FETCH cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (com) begin
          state_d = (word_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (last_lane) begin
          state_d = (words_left == CW'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word address and remaining-word counter; address wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      words_left <= '0;
    end else if (state_q == IDLE && com) begin
      addr_q     <= base_addr;
      words_left <= word_count;
    end else if (state_q == SEND && last_lane) begin
      addr_q     <= addr_q + I'(1);
      words_left <= words_left - CW'(1);
    end
  end

  assign bus.mem_addr = (state_q == FETCH || state_q == SEND) ? addr_q : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  lane_serializer #(
    .N (N),
    .R (R)
  ) u_ser (
    .clk        (clk),
    .rst_n      (reset),
    .load       (load),
    .lanes_in   (bus.mem_rd),
    .byte_out   (bus.byte_out),
    .byte_valid (bus.byte_valid),
    .byte_ready (bus.byte_ready),
    .last_lane  (last_lane)
  );

endmodule

// File: tb/tb_com_stream_tx.sv
// Testbench for com_stream_tx: randomized and directed transfers checked
// against a queue of expected (address, byte) pairs built from memory contents.
module tb_com_stream_tx;
  import com_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        com = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        done;
  int          cyc = 0;

  com_stream_tx_if #(.I(32), .N(8), .R(6)) sif ();

  com_stream_tx #(.I(32), .N(8), .R(6), .CW(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .com        (com),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (sif.master),
    .busy       (busy),
    .done       (done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: fixed word at address 10 when salt is 0, otherwise a pattern.
  logic [7:0] salt = '0;

  function automatic lane_vec_t mem_word(logic [31:0] a, logic [7:0] s);
    lane_vec_t w;
    if (a == 32'd10 && s == 8'd0) begin
      w = 48'h66_55_44_33_22_11;
    end else begin
      for (int k = 0; k < 6; k++) begin
        w[k] = 8'(a[7:0] * 8'd7 + k * 13) ^ s ^ a[15:8] ^ a[31:24];
      end
    end
    return w;
  endfunction

  assign sif.mem_rd = mem_word(sif.mem_addr, salt);

  // Scoreboard.
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
  } exp_t;

  exp_t exp_q[$];

  task automatic load_model(logic [31:0] base, int count);
    for (int w = 0; w < count; w++) begin
      logic [31:0] a;
      lane_vec_t   wd;
      a  = base + 32'(w);
      wd = mem_word(a, salt);
      for (int k = 0; k < 6; k++) exp_q.push_back('{addr: a, b: wd[k]});
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  int rdy_mode = 0;
  int rdy_ph   = 0;

  initial begin
    sif.byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       sif.byte_ready = 1'b1;
        1: begin
          sif.byte_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
          rdy_ph++;
        end
        default: sif.byte_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor.
  int         hs_count, done_count, valid_cycles, first_valid_cyc, done_cyc;
  int         hs_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = '0;
  logic       done_prev  = 1'b0;
  logic       busy_after_done = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
      done_prev  = 1'b0;
      continue;
    end
    if (prev_stall) begin
      check_eq("hold_valid", sif.byte_valid, 1);
      check_eq("hold_byte", sif.byte_out, prev_byte);
    end
    if (done_prev) busy_after_done = busy;
    if (sif.byte_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (done) begin
      check_eq("done_excl_valid", sif.byte_valid, 0);
      done_count++;
      done_cyc = cyc;
    end
    if (sif.byte_valid && sif.byte_ready) begin
      hs_count++;
      hs_cyc.push_back(cyc);
      check_eq("exp_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("byte", sif.byte_out, e.b);
        check_eq("mem_addr", sif.mem_addr, e.addr);
      end
    end
    prev_stall = sif.byte_valid && !sif.byte_ready;
    prev_byte  = sif.byte_out;
    done_prev  = done;
  end

  task automatic clear_mon();
    hs_count        = 0;
    done_count      = 0;
    valid_cycles    = 0;
    first_valid_cyc = -1;
    done_cyc        = -1;
    busy_after_done = 1'b1;
    hs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic start(logic [31:0] base, int count, output int c0);
    @(posedge clk);
    #1;
    base_addr  = base;
    word_count = 16'(count);
    com        = 1'b1;
    c0         = cyc;
    @(posedge clk);
    #1;
    com = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done_count != 0, 1);
  endtask

  task automatic wait_hs(int target, int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("hs_reached", hs_count >= target, 1);
  endtask

  task automatic run_xfer(logic [31:0] base, int count, logic [7:0] s, int mode, output int c0);
    salt     = s;
    rdy_mode = mode;
    rdy_ph   = 0;
    clear_mon();
    load_model(base, count);
    start(base, count, c0);
    wait_done(count * 60 + 20);
    repeat (4) @(negedge clk);
    check_eq("all_bytes_sent", exp_q.size(), 0);
    check_eq("hs_total", hs_count, count * 6);
    check_eq("one_done", done_count, 1);
    check_eq("busy_after_done", busy_after_done, 0);
  endtask

  initial begin
    int c0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_mem_addr", sif.mem_addr, 0);
    check_eq("rst_byte_out", sif.byte_out, 0);
    check_eq("rst_valid", sif.byte_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single word at address 10.
    run_xfer(32'd10, 1, 8'd0, 0, c0);
    check_eq("first_valid_lat", first_valid_cyc - c0, 2);
    check_eq("bytes_consecutive", hs_cyc[5] - hs_cyc[0], 5);
    check_eq("done_after_last", done_cyc - hs_cyc[5], 1);

    // Back-pressure on the same word.
    run_xfer(32'd10, 1, 8'd0, 1, c0);

    // Two words across the address wrap.
    run_xfer(32'hFFFF_FFFF, 2, 8'h3C, 0, c0);
    check_eq("word_spacing", hs_cyc[6] - hs_cyc[0], 7);
    check_eq("wrap_first_lat", first_valid_cyc - c0, 2);

    // Zero word count.
    clear_mon();
    rdy_mode = 0;
    start(32'd50, 0, c0);
    wait_done(10);
    repeat (4) @(negedge clk);
    check_eq("zero_done_lat", done_cyc - c0, 1);
    check_eq("zero_no_valid", valid_cycles, 0);
    check_eq("zero_one_done", done_count, 1);
    check_eq("zero_busy_after", busy_after_done, 0);

    // COM re-pulsed while sending must be ignored.
    clear_mon();
    salt = 8'h91;
    load_model(32'd200, 2);
    start(32'd200, 2, c0);
    wait_hs(2, 50);
    @(posedge clk);
    #1;
    base_addr  = 32'd999;
    word_count = 16'd5;
    com        = 1'b1;
    @(posedge clk);
    #1 com = 1'b0;
    wait_done(200);
    repeat (10) @(negedge clk);
    check_eq("busy_com_done", done_count, 1);
    check_eq("busy_com_hs", hs_count, 12);
    check_eq("busy_com_exp", exp_q.size(), 0);
    check_eq("busy_com_idle", busy, 0);

    // Randomized transfers with random back-pressure.
    for (int t = 0; t < 6; t++) begin
      run_xfer($urandom, 1 + int'($urandom % 3), 8'($urandom_range(1, 255)), 2, c0);
    end

    // Reset in the middle of a 3-word transfer.
    clear_mon();
    salt     = 8'h27;
    rdy_mode = 0;
    load_model(32'd100, 3);
    start(32'd100, 3, c0);
    wait_hs(1, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_mem_addr", sif.mem_addr, 0);
    check_eq("abort_byte_out", sif.byte_out, 0);
    check_eq("abort_valid", sif.byte_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_state", dut.state_q, IDLE);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", done_count, 0);
    check_eq("abort_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
